// File: rtl/network_pkg.sv
// Shared types and helpers for the network stream loader.
//   WORD_W    : stream word width (signed Q-format).
//   state_e   : loader FSM states.
//   region_e  : destination region of an incoming word.
//   cnt_width : width needed to count 0..n-1 (minimum 1 bit).
package network_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_e;

  typedef enum logic [1:0] {RegW, RegB, RegX} region_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/result_serializer.sv
// Captures the network output bus and emits it word by word on a valid/ready stream.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset.
//   capture    : load y into the result buffer and start draining from word 0.
//   y          : network output bus, word k at [k*16 +: 16].
//   m_ready    : downstream accepts the current word.
//   m_valid    : a result word is being presented.
//   m_data     : current word (0 when idle).
//   m_last     : current word is the final one (index N_Y-1).
//   done       : handshake of the final word happens this cycle.
module result_serializer
  import network_pkg::*;
#(
  parameter int unsigned N_Y = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture,
  input  logic [N_Y*WORD_W-1:0] y,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [WORD_W-1:0]     m_data,
  output logic                  m_last,
  output logic                  done
);

  localparam int unsigned IW = cnt_width(N_Y);

  logic [N_Y*WORD_W-1:0] res_q;
  logic [IW-1:0]         idx_q;
  logic                  active_q;
  logic                  is_last;
  logic [WORD_W-1:0]     word;

  assign is_last = (idx_q == IW'(N_Y - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else if (capture) begin
      res_q    <= y;
      idx_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q && m_ready) begin
      if (is_last) begin
        active_q <= 1'b0;
        idx_q    <= '0;
      end else begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  // Constant-index mux keeps the select free of variable part-selects.
  always_comb begin
    word = '0;
    for (int k = 0; k < N_Y; k++) begin
      if (idx_q == IW'(k)) word = res_q[k*WORD_W +: WORD_W];
    end
  end

  assign m_valid = active_q;
  assign m_data  = active_q ? word : '0;
  assign m_last  = active_q && is_last;
  assign done    = active_q && m_ready && is_last;

endmodule

// File: rtl/network_stream_loader.sv
// Narrow-bus wrapper for the packed-parameter network block. Deserialises a 16-bit
// stream (weights, biases, inputs) into packed w/b/x buses, pulses net_start, waits
// for net_done, then serialises net_y back out on a 16-bit valid/ready stream.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset.
//   s_valid/s_ready/s_data/s_last  : input word stream.
//   x_only                         : sampled on word 0; frame carries only N_X inputs.
//   x_out/w_out/b_out              : packed network parameters and inputs.
//   net_start/net_done/net_y       : network control and result.
//   m_valid/m_ready/m_data/m_last  : output word stream.
//   busy                           : not idle (idle = LOAD with no partial frame).
//   frame_err                      : one-cycle pulse on a malformed frame.
module network_stream_loader
  import network_pkg::*;
#(
  parameter int unsigned N_X = 2,
  parameter int unsigned N_W = 9,
  parameter int unsigned N_B = 4,
  parameter int unsigned N_Y = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_W-1:0]     s_data,
  input  logic                  s_last,
  input  logic                  x_only,
  output logic [N_X*WORD_W-1:0] x_out,
  output logic [N_W*WORD_W-1:0] w_out,
  output logic [N_B*WORD_W-1:0] b_out,
  output logic                  net_start,
  input  logic                  net_done,
  input  logic [N_Y*WORD_W-1:0] net_y,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_W-1:0]     m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int unsigned F_FULL = N_W + N_B + N_X;
  localparam int unsigned CW     = cnt_width(F_FULL + 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  xo_q, xo_d;
  logic                  err_q, err_d;
  logic                  rdy_en_q;
  logic [N_X*WORD_W-1:0] x_q;
  logic [N_W*WORD_W-1:0] w_q;
  logic [N_B*WORD_W-1:0] b_q;

  logic                  xo_cur;
  logic [CW-1:0]         f_last;
  region_e               region;
  logic [CW-1:0]         slot;
  logic                  wr_en;
  logic                  capture;
  logic                  ser_done;

  // x_only applies from word 0 onwards, so word 0 uses the live pin.
  always_comb begin
    xo_cur = (cnt_q == '0) ? x_only : xo_q;
    f_last = xo_cur ? CW'(N_X - 1) : CW'(F_FULL - 1);
    if (xo_cur) begin
      region = RegX;
      slot   = cnt_q;
    end else if (cnt_q < CW'(N_W)) begin
      region = RegW;
      slot   = cnt_q;
    end else if (cnt_q < CW'(N_W + N_B)) begin
      region = RegB;
      slot   = cnt_q - CW'(N_W);
    end else begin
      region = RegX;
      slot   = cnt_q - CW'(N_W + N_B);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    xo_d      = xo_q;
    err_d     = 1'b0;
    s_ready   = 1'b0;
    net_start = 1'b0;
    wr_en     = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      LOAD: begin
        s_ready = rdy_en_q;
        if (s_valid && rdy_en_q) begin
          wr_en = 1'b1;
          if (cnt_q == '0) xo_d = x_only;
          if (cnt_q == f_last) begin
            cnt_d = '0;
            if (s_last) state_d = START;
            else        err_d   = 1'b1;
          end else if (s_last) begin
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      START: begin
        net_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (net_done) begin
          capture = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ser_done) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      xo_q     <= 1'b0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xo_q     <= xo_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Region storage only changes in LOAD, so the buses are stable while the network runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      w_q <= '0;
      b_q <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < N_W; k++) begin
        if (region == RegW && slot == CW'(k)) w_q[k*WORD_W +: WORD_W] <= s_data;
      end
      for (int k = 0; k < N_B; k++) begin
        if (region == RegB && slot == CW'(k)) b_q[k*WORD_W +: WORD_W] <= s_data;
      end
      for (int k = 0; k < N_X; k++) begin
        if (region == RegX && slot == CW'(k)) x_q[k*WORD_W +: WORD_W] <= s_data;
      end
    end
  end

  result_serializer #(
    .N_Y (N_Y)
  ) u_result_serializer (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (capture),
    .y       (net_y),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .done    (ser_done)
  );

  assign x_out     = x_q;
  assign w_out     = w_q;
  assign b_out     = b_q;
  assign frame_err = err_q;
  assign busy      = !(state_q == LOAD && cnt_q == '0);

endmodule

// File: tb/tb_network_stream_loader.sv
module tb_network_stream_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared input stream drives both instances (default N_Y=1 and N_Y=3).
  logic        s_valid, s_last, x_only, net_done;
  logic [15:0] s_data;
  logic        s_ready, net_start, m_valid, m_ready, m_last, busy, frame_err;
  logic [31:0] x_out;
  logic [143:0] w_out;
  logic [63:0] b_out;
  logic [15:0] net_y, m_data;
  logic        s_ready3, net_start3, m_valid3, m_ready3, m_last3, busy3, frame_err3;
  logic [31:0] x_out3;
  logic [143:0] w_out3;
  logic [63:0] b_out3;
  logic [47:0] net_y3;
  logic [15:0] m_data3;

  network_stream_loader dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .x_only(x_only), .x_out(x_out), .w_out(w_out), .b_out(b_out),
    .net_start(net_start), .net_done(net_done), .net_y(net_y), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy), .frame_err(frame_err)
  );

  network_stream_loader #(.N_Y(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready3), .s_data(s_data),
    .s_last(s_last), .x_only(x_only), .x_out(x_out3), .w_out(w_out3), .b_out(b_out3),
    .net_start(net_start3), .net_done(net_done), .net_y(net_y3), .m_valid(m_valid3),
    .m_ready(m_ready3), .m_data(m_data3), .m_last(m_last3), .busy(busy3),
    .frame_err(frame_err3)
  );

  typedef struct packed {logic [15:0] d; logic l;} exp_t;
  typedef struct {logic [15:0] d; logic l; logic xo;} word_t;

  exp_t  sb1[$];
  exp_t  sb3[$];
  word_t fq[$];

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int starts3 = 0;
  int errs = 0;
  int exp_starts = 0;

  logic [143:0] ew;
  logic [63:0]  eb;
  logic [31:0]  ex;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout or unexpected event", name);
  endtask

  // Monitor for the N_Y=1 instance.
  initial begin
    logic        hold;
    logic [15:0] hold_d;
    logic        rdy_next;
    exp_t        e;
    hold = 1'b0; hold_d = '0; rdy_next = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
        rdy_next = 1'b0;
      end else begin
        starts += int'(net_start);
        errs   += int'(frame_err);
        if (rdy_next) begin
          chk("ready_after_drain", {s_ready, m_valid}, 2'b10);
          rdy_next = 1'b0;
        end
        if (hold) chk("m1_stall_stable", {m_valid, m_data}, {1'b1, hold_d});
        if (m_valid && m_ready) begin
          if (sb1.size() == 0) fail_now("m1_unexpected_word");
          else begin
            e = sb1.pop_front();
            chk("m1_word", {m_data, m_last}, {e.d, e.l});
            rdy_next = m_last;
          end
          hold = 1'b0;
        end else if (m_valid) begin
          hold = 1'b1;
          hold_d = m_data;
        end else hold = 1'b0;
      end
    end
  end

  // Monitor for the N_Y=3 instance.
  initial begin
    logic        hold;
    logic [15:0] hold_d;
    exp_t        e;
    hold = 1'b0; hold_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 1'b0;
      else begin
        starts3 += int'(net_start3);
        if (hold) chk("m3_stall_stable", {m_valid3, m_data3}, {1'b1, hold_d});
        if (m_valid3 && m_ready3) begin
          if (sb3.size() == 0) fail_now("m3_unexpected_word");
          else begin
            e = sb3.pop_front();
            chk("m3_word", {m_data3, m_last3}, {e.d, e.l});
          end
          hold = 1'b0;
        end else if (m_valid3) begin
          hold = 1'b1;
          hold_d = m_data3;
        end else hold = 1'b0;
      end
    end
  end

  task automatic push_word(input logic [15:0] d, input logic l, input logic xo);
    word_t w;
    w.d = d; w.l = l; w.xo = xo;
    fq.push_back(w);
  endtask

  task automatic set_full(input int wb, input int bb, input logic [15:0] x0,
                          input logic [15:0] x1);
    fq.delete();
    for (int k = 0; k < 9; k++) begin
      push_word(16'(wb + k), 1'b0, 1'b0);
      ew[k*16 +: 16] = 16'(wb + k);
    end
    for (int k = 0; k < 4; k++) begin
      push_word(16'(bb + k), 1'b0, 1'b0);
      eb[k*16 +: 16] = 16'(bb + k);
    end
    push_word(x0, 1'b0, 1'b0);
    push_word(x1, 1'b1, 1'b0);
    ex = {x1, x0};
  endtask

  // Plays fq; returns 1 ns after the edge that accepted the final word.
  task automatic play();
    int wd;
    wd = 0;
    while (!(s_ready && s_ready3) && wd < 50) begin
      @(posedge clk); #1; wd++;
    end
    if (wd >= 50) fail_now("play_wait_ready");
    foreach (fq[i]) begin
      s_valid = 1'b1; s_data = fq[i].d; s_last = fq[i].l; x_only = fq[i].xo;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0; x_only = 1'b0;
  endtask

  task automatic chk_regions(input string tag);
    chk({tag, "_w"}, w_out, ew);
    chk({tag, "_b"}, b_out, eb);
    chk({tag, "_x"}, x_out, ex);
    chk({tag, "_w3"}, w_out3, ew);
  endtask

  task automatic chk_started(input string tag);
    chk({tag, "_start"}, {net_start, net_start3}, 2'b11);
    exp_starts++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_regions"}, {x_out, w_out, b_out}, '0);
    chk({tag, "_ctrl"}, {s_ready, net_start, m_valid, m_data, m_last, frame_err, busy}, '0);
    chk({tag, "_regions3"}, {x_out3, w_out3, b_out3}, '0);
    chk({tag, "_ctrl3"}, {s_ready3, net_start3, m_valid3, m_data3, m_last3, frame_err3, busy3},
        '0);
  endtask

  // pat3 bit c is m_ready3 in drain cycle c.
  task automatic drain(input logic [15:0] y1, input logic [47:0] y3, input logic [7:0] pat3);
    exp_t e;
    int   wd;
    e.d = y1; e.l = 1'b1;
    sb1.push_back(e);
    for (int k = 0; k < 3; k++) begin
      e.d = y3[k*16 +: 16]; e.l = (k == 2);
      sb3.push_back(e);
    end
    net_y = y1; net_y3 = y3; net_done = 1'b1;
    @(posedge clk); #1;
    net_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      m_ready3 = (c < 8) ? pat3[c] : 1'b1;
      @(posedge clk); #1;
    end
    wd = 0;
    while ((busy || busy3 || m_valid || m_valid3) && wd < 40) begin
      @(posedge clk); #1; wd++;
    end
    if (wd >= 40) fail_now("drain_done");
    chk("sb1_empty", sb1.size(), 0);
    chk("sb3_empty", sb3.size(), 0);
  endtask

  initial begin
    s_valid = 0; s_last = 0; x_only = 0; s_data = 0; net_done = 0;
    net_y = 0; net_y3 = 0; m_ready = 1; m_ready3 = 1;
    ew = '0; eb = '0; ex = '0;

    #12 chk_zero("reset");
    rst_n = 1'b1;
    #1 chk("s_ready_before_clk", {s_ready, s_ready3}, 2'b00);
    @(posedge clk); #1;
    chk("s_ready_after_release", {s_ready, s_ready3}, 2'b11);

    // Full frame: weights 1..9, biases 10..13, x = {0x0100, 0x0200}.
    set_full(1, 10, 16'h0100, 16'h0200);
    play();
    chk_started("full1");
    for (int k = 0; k < 9; k++) chk($sformatf("w_word%0d", k), w_out[k*16 +: 16], 16'(k + 1));
    chk("b_word0", b_out[15:0], 16'd10);
    chk("x_word1", x_out[31:16], 16'h0200);
    chk_regions("full1");
    @(posedge clk); #1;
    chk("start_single_pulse", {net_start, net_start3, busy}, 3'b001);
    chk("start_count1", starts, exp_starts);
    drain(16'h1234, 48'h0C03_0B02_0A01, 8'hFF);

    // x_only frame: only x changes; x_only sampled on word 0 only.
    fq.delete();
    push_word(16'h0300, 1'b0, 1'b1);
    push_word(16'h0400, 1'b1, 1'b0);
    ex = 32'h0400_0300;
    play();
    chk_started("xonly");
    chk_regions("xonly");
    @(posedge clk); #1;
    chk("start_count2", starts, exp_starts);
    drain(16'h5678, 48'h0003_0002_0001, 8'hFF);

    // Spurious net_done while loading.
    net_done = 1'b1;
    @(posedge clk); #1;
    net_done = 1'b0;
    chk("spurious_done", {busy, m_valid, busy3, m_valid3}, 4'b0000);
    @(posedge clk); #1;
    chk("spurious_done_next", {busy, m_valid, busy3, m_valid3}, 4'b0000);

    // s_last on word 5 of a full frame.
    fq.delete();
    for (int k = 0; k < 6; k++) push_word(16'(16'h00A0 + k), k == 5, 1'b0);
    play();
    chk("err_pulse", {frame_err, frame_err3, net_start, net_start3}, 4'b1100);
    chk("err_w_lo", w_out[79:0], 80'h00A4_00A3_00A2_00A1_00A0);
    chk("err_w_hi", w_out[143:96], ew[143:96]);
    @(posedge clk); #1;
    chk("err_gone", {frame_err, busy, net_start}, 3'b000);
    chk("err_count", errs, 1);
    chk("start_count_err", starts, exp_starts);

    set_full(16'h10, 16'h20, 16'h0030, 16'h0031);
    play();
    chk_started("after_err");
    chk_regions("after_err");
    @(posedge clk); #1;
    // N_Y=3 stream with m_ready 1-0-0-1-1.
    drain(16'h9ABC, 48'hCCC3_BBB2_AAA1, 8'b0001_1001);

    // Reset while in WAIT.
    set_full(16'h40, 16'h50, 16'h0060, 16'h0061);
    play();
    chk_started("pre_wait_rst");
    @(posedge clk); #1;
    chk("in_wait", {busy, busy3, net_start}, 3'b110);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_wait");
    ew = '0; eb = '0; ex = '0;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in mid-DRAIN.
    set_full(16'h40, 16'h50, 16'h0060, 16'h0061);
    play();
    chk_started("pre_drain_rst");
    @(posedge clk); #1;
    m_ready = 1'b0; m_ready3 = 1'b0;
    net_y = 16'hDEAD; net_y3 = 48'hBEEF_BEEF_BEEF; net_done = 1'b1;
    @(posedge clk); #1;
    net_done = 1'b0;
    @(posedge clk); #1;
    chk("drain_stalled", {m_valid, m_valid3, m_data}, {2'b11, 16'hDEAD});
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_drain");
    ew = '0; eb = '0; ex = '0;
    sb1.delete(); sb3.delete();
    m_ready = 1'b1; m_ready3 = 1'b1;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    set_full(16'h70, 16'h80, 16'h0090, 16'h0091);
    play();
    chk_started("post_rst");
    chk_regions("post_rst");
    @(posedge clk); #1;
    drain(16'h4321, 48'h0F03_0F02_0F01, 8'hFF);
    chk("start_count_final", starts, exp_starts);
    chk("start3_count_final", starts3, exp_starts);
    chk("err_count_final", errs, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
